// File: rtl/fp_minmax_reduce.sv
// Streaming IEEE-754 min/max reduction over a counted burst of elements (double or single precision).
// Optional sticky signaling-NaN flag on out_nv when FP_MINMAX_NV_FLAG_EN is defined.
module fp_minmax_reduce #(
    parameter int BUS_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op,
    input  logic [7:0]           count,
    input  logic                 in_valid,
    input  logic [BUS_WIDTH-1:0] in_data,
    output logic                 in_ready,
    output logic                 busy,
    output logic                 out_valid,
    output logic [BUS_WIDTH-1:0] out_data,
    input  logic                 out_ready
`ifdef FP_MINMAX_NV_FLAG_EN
    ,
    output logic                 out_nv
`endif
);

    localparam int EW = (BUS_WIDTH == 64) ? 11 : 8;
    localparam int MW = BUS_WIDTH - 1 - EW;
    localparam logic [BUS_WIDTH-1:0] CANON_NAN = {1'b0, {EW{1'b1}}, 1'b1, {(MW-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [BUS_WIDTH-1:0] acc;
    logic [7:0]           remaining;
    logic                 op_q;
    logic                 first_q;
    logic                 start_acc;
    logic                 accept;

    function automatic logic is_nan(input logic [BUS_WIDTH-1:0] x);
        return (&x[BUS_WIDTH-2:MW]) && (|x[MW-1:0]);
    endfunction

    // Sign-magnitude ordering; treats -0 as strictly below +0, which gives the
    // required signed-zero results for both min and max.
    function automatic logic fp_less(input logic [BUS_WIDTH-1:0] a,
                                     input logic [BUS_WIDTH-1:0] b);
        logic sa, sb;
        sa = a[BUS_WIDTH-1];
        sb = b[BUS_WIDTH-1];
        if (sa != sb)
            return sa;
        else if (!sa)
            return a[BUS_WIDTH-2:0] < b[BUS_WIDTH-2:0];
        else
            return a[BUS_WIDTH-2:0] > b[BUS_WIDTH-2:0];
    endfunction

    function automatic logic [BUS_WIDTH-1:0] fp_select(input logic [BUS_WIDTH-1:0] a,
                                                       input logic [BUS_WIDTH-1:0] b,
                                                       input logic                 is_max);
        logic a_lt_b;
        a_lt_b = fp_less(a, b);
        if (is_nan(a) && is_nan(b))
            return CANON_NAN;
        else if (is_nan(a))
            return b;
        else if (is_nan(b))
            return a;
        else if (is_max)
            return a_lt_b ? b : a;
        else
            return a_lt_b ? a : b;
    endfunction

    assign start_acc = (state == IDLE) && start && (count != 8'd0);
    assign accept    = (state == ACCUM) && in_valid;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_acc) state_next = ACCUM;
            ACCUM:   if (accept && remaining == 8'd1) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            remaining <= 8'd0;
            op_q      <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (start_acc) begin
                op_q      <= op;
                remaining <= count;
                first_q   <= 1'b1;
            end
            if (accept) begin
                acc       <= fp_select(first_q ? in_data : acc, in_data, op_q);
                remaining <= remaining - 8'd1;
                first_q   <= 1'b0;
            end
        end
    end

    assign in_ready  = (state == ACCUM);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign out_data  = out_valid ? acc : '0;

`ifdef FP_MINMAX_NV_FLAG_EN
    logic nv_q;

    function automatic logic is_snan(input logic [BUS_WIDTH-1:0] x);
        return is_nan(x) && !x[MW-1];
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            nv_q <= 1'b0;
        else if (start_acc)
            nv_q <= 1'b0;
        else if (accept && is_snan(in_data))
            nv_q <= 1'b1;
    end

    assign out_nv = out_valid & nv_q;
`endif

endmodule

// File: tb/tb_fp_minmax_reduce.sv
// Directed-vector bench for fp_minmax_reduce (BUS_WIDTH=64): stimulus queues expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_fp_minmax_reduce;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        op;
    logic [7:0]  count;
    logic        in_valid;
    logic [63:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready;
`ifdef FP_MINMAX_NV_FLAG_EN
    logic        out_nv;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [63:0] exp_q[$];
    logic        exp_nv_q[$];

    localparam logic [63:0] P_ONE  = 64'h3FF0000000000000;
    localparam logic [63:0] N_ONE  = 64'hBFF0000000000000;
    localparam logic [63:0] P_TWO  = 64'h4000000000000000;
    localparam logic [63:0] N_THR  = 64'hC008000000000000;
    localparam logic [63:0] QNAN   = 64'h7FF8000000000000;
    localparam logic [63:0] SNAN   = 64'h7FF4000000000000;
    localparam logic [63:0] P_ZERO = 64'h0000000000000000;
    localparam logic [63:0] N_ZERO = 64'h8000000000000000;
    localparam logic [63:0] P_INF  = 64'h7FF0000000000000;

    fp_minmax_reduce #(.BUS_WIDTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .count     (count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .busy      (busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef FP_MINMAX_NV_FLAG_EN
        ,
        .out_nv    (out_nv)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total_cnt++;
        if (act === expv)
            pass_cnt++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_red(input logic o, input logic [7:0] n);
        start = 1'b1;
        op    = o;
        count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [63:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_result(input logic [63:0] d, input logic nv);
        exp_q.push_back(d);
        exp_nv_q.push_back(nv);
    endtask

    task automatic run2(input logic o, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] r, input logic nv);
        expect_result(r, nv);
        begin_red(o, 8'd2);
        send(a);
        send(b);
        tick();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (!out_valid)
                check("out_data_zero_when_idle", out_data, 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_result: got %h, expected no output", out_data);
                end else begin
                    logic [63:0] e;
                    logic        env;
                    e   = exp_q.pop_front();
                    env = exp_nv_q.pop_front();
                    check("result", out_data, e);
`ifdef FP_MINMAX_NV_FLAG_EN
                    check("out_nv", {63'd0, out_nv}, {63'd0, env});
`else
                    if (env) ; // flag not present in this build
`endif
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        op        = 1'b0;
        count     = 8'd0;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_data",  out_data,           64'd0);
        rst = 1'b0;
        tick();

        // min of 1.0, -3.0, 2.0 back-to-back; result one cycle after last accept
        expect_result(N_THR, 1'b0);
        begin_red(1'b0, 8'd3);
        check("accum_in_ready", {63'd0, in_ready}, 64'd1);
        send(P_ONE);
        send(N_THR);
        send(P_TWO);
        check("latency_out_valid", {63'd0, out_valid}, 64'd1);
        tick();
        check("idle_after_done", {63'd0, busy}, 64'd0);

        run2(1'b1, QNAN, P_ONE, P_ONE, 1'b0);
        run2(1'b1, SNAN, SNAN, QNAN, 1'b1);
        run2(1'b0, P_ZERO, N_ZERO, N_ZERO, 1'b0);
        run2(1'b1, P_ZERO, N_ZERO, P_ZERO, 1'b0);
        run2(1'b0, N_ZERO, P_ZERO, N_ZERO, 1'b0);
        run2(1'b1, N_ZERO, P_ZERO, P_ZERO, 1'b0);
        run2(1'b1, N_THR, N_ONE, N_ONE, 1'b0);
        run2(1'b0, P_INF, P_ONE, P_ONE, 1'b0);
        run2(1'b1, P_ONE, QNAN, P_ONE, 1'b0);

        // sparse input and stalled consumer
        expect_result(P_TWO, 1'b0);
        begin_red(1'b1, 8'd3);
        send(P_ONE);
        tick();
        send(P_TWO);
        tick();
        out_ready = 1'b0;
        send(N_THR);
        for (int i = 0; i < 5; i++) begin
            check("stall_out_valid", {63'd0, out_valid}, 64'd1);
            check("stall_out_data",  out_data,           P_TWO);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("idle_after_stall", {63'd0, busy}, 64'd0);

        // zero-count start and in_valid in IDLE are ignored
        start = 1'b1;
        count = 8'd0;
        tick();
        start = 1'b0;
        check("count0_busy", {63'd0, busy}, 64'd0);
        in_valid = 1'b1;
        in_data  = N_THR;
        tick();
        tick();
        in_valid = 1'b0;
        check("idle_in_valid_busy", {63'd0, busy}, 64'd0);

        // start pulsed mid-ACCUM must not alter op/remaining
        expect_result(P_ONE, 1'b0);
        begin_red(1'b0, 8'd2);
        send(P_ONE);
        begin_red(1'b1, 8'd5);
        check("start_in_accum_busy", {63'd0, busy}, 64'd1);
        send(P_TWO);
        check("start_in_accum_done", {63'd0, out_valid}, 64'd1);
        tick();

        // reset mid-reduction discards the partial result
        begin_red(1'b0, 8'd3);
        send(N_THR);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy",      {63'd0, busy},      64'd0);
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_in_ready",  {63'd0, in_ready},  64'd0);
        tick();
        tick();
        expect_result(P_ONE, 1'b0);
        begin_red(1'b0, 8'd1);
        send(P_ONE);
        tick();

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            tick();
        if (exp_q.size() != 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending results, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fp_minmax_reduce.md
FP_MINMAX_REDUCE -- requirements
Module: fp_minmax_reduce

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 64, meaning FP operand width: 64 = double, 32 = single; no other values are legal.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin a reduction; sampled only in IDLE.
REQ-005 SHALL have port op, input, 1 bit: 0 = min, 1 = max; latched with start.
REQ-006 SHALL have port count, input, 8 bits: number of elements to reduce; latched with start.
REQ-007 SHALL have port in_valid, input, 1 bit: in_data holds an element.
REQ-008 SHALL have port in_data, input, BUS_WIDTH bits: element operand.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts an element this cycle.
REQ-010 SHALL have port busy, output, 1 bit: state is not IDLE.
REQ-011 SHALL have port out_valid, output, 1 bit: reduction result is available.
REQ-012 SHALL have port out_data, output, BUS_WIDTH bits: reduction result.
REQ-013 SHALL have port out_ready, input, 1 bit: consumer takes the result.

Function
REQ-014 SHALL implement the FSM states IDLE, ACCUM and DONE with registered state, accumulator acc[BUS_WIDTH-1:0], remaining[7:0] and op_q.
REQ-015 SHALL go IDLE->ACCUM when start=1 and count!=0, latching op_q=op and remaining=count; start with count=0 SHALL be ignored.
REQ-016 SHALL assert in_ready=1 only in ACCUM; an element is accepted only on in_valid&in_ready; at most one element per cycle.
REQ-017 SHALL load acc = f(in_data,in_data) on the first element and acc = f(acc,in_data) on each later element, where f is FP min (op_q=0) or FP max (op_q=1).
REQ-018 SHALL give f these semantics: one NaN operand -> return the other operand; both NaN -> canonical NaN (64: 0x7FF8000000000000, 32: 0x7FC00000); min(-0,+0) = -0 and max(-0,+0) = +0 in either operand order; otherwise the numerically smaller or larger value.
REQ-019 SHALL decrement remaining on each accepted element and go ACCUM->DONE on the accept where remaining=1.
REQ-020 SHALL, in DONE, drive out_valid=1 and out_data=acc, holding both stable until out_ready=1, then go DONE->IDLE in the same edge.
REQ-021 SHALL assert out_valid in the cycle after the last element handshake; throughput is 1 element per cycle while in_valid stays high.
REQ-022 SHALL ignore start outside IDLE, with no effect on op_q, remaining or acc.
REQ-023 SHALL drive out_data=0 whenever out_valid=0.
REQ-024 SHALL ignore in_valid held high in IDLE or DONE, with no state change.

Reset
REQ-025 SHALL on rst=1 at a clock edge force state=IDLE, acc=0, remaining=0, op_q=0, and every sticky flag = 0; rst has priority over all other inputs.
REQ-026 SHALL reset the outputs to in_ready=0, busy=0, out_valid=0, out_data=0 (and out_nv=0 when present).
REQ-027 SHALL on reset mid-ACCUM or mid-DONE discard the partial result; no out_valid follows for that reduction.

Configuration
REQ-028 SHALL, when macro FP_MINMAX_NV_FLAG_EN is defined, add output port out_nv (1 bit): a sticky flag, cleared on the start accept, set when any accepted element is a signaling NaN (exponent all ones, mantissa nonzero, mantissa MSB = 0), and valid with out_valid.
REQ-029 SHALL, without FP_MINMAX_NV_FLAG_EN, have no out_nv port and no sNaN detection logic; all other behaviour is identical.

Verification (BUS_WIDTH=64)
REQ-030 SHALL cover: start, op=0, count=3, elements 0x3FF0000000000000 (1.0), 0xC008000000000000 (-3.0), 0x4000000000000000 (2.0) back-to-back -> out_valid one cycle after the third accept, out_data=0xC008000000000000.
REQ-031 SHALL cover: op=1, count=2, elements 0x7FF8000000000000 then 0x3FF0000000000000 -> out_data=0x3FF0000000000000; with op=1, count=2, both elements 0x7FF4000000000000 -> out_data=0x7FF8000000000000, and out_nv=1 when the macro is on.
REQ-032 SHALL cover: op=0, count=2, elements 0x0000000000000000 then 0x8000000000000000 -> out_data=0x8000000000000000; op=1 with the same elements -> 0x0000000000000000.
REQ-033 SHALL cover: in_valid toggled every other cycle and out_ready held low 5 cycles in DONE -> correct result; out_valid/out_data stable all 5 cycles; IDLE on the cycle after out_ready.
REQ-034 SHALL cover: start with count=0 -> busy stays 0; start pulsed in ACCUM -> ignored.
REQ-035 SHALL cover: rst asserted after 1 of 3 elements -> IDLE next cycle, busy=0, no out_valid; a new count=1 reduction of 1.0 then returns 0x3FF0000000000000.
